// File: rtl/rgb_led_pkg.sv
// Shared definitions for the RGB LED array controller.
// Optional feature macro: RGB_LED_BREATHE_EN (BREATHE mode and triangle-wave timebase).
package rgb_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STEADY  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

  localparam int unsigned R_BIT = 2;
  localparam int unsigned G_BIT = 1;
  localparam int unsigned B_BIT = 0;

  // Width of an LED index; a single LED still gets a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rgb_pwm_timebase.sv
// Shared timebase for all LEDs: tick prescaler, PWM step counter, frame_start,
// blink phase and, with RGB_LED_BREATHE_EN defined, the global breathe level.
module rgb_pwm_timebase
  import rgb_led_pkg::*;
#(
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned TICK_DIV   = 195,
  parameter int unsigned BLINK_HALF = 25000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             blink_sync_i,
  output logic [PWM_W-1:0] pwm_cnt_o,
  output logic             frame_start_o,
  output logic             blink_state_o
`ifdef RGB_LED_BREATHE_EN
  ,
  output logic [PWM_W-1:0] breathe_lvl_o
`endif
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_state_q, blink_state_d;
  logic             tick;

  assign tick          = (presc_q == PRE_LAST);
  assign frame_start_o = tick & (pwm_cnt_q == '1);
  assign pwm_cnt_o     = pwm_cnt_q;
  assign blink_state_o = blink_state_q;

  // Prescaler and PWM step counter; the counter wraps naturally at 2^PWM_W.
  always_comb begin
    presc_d   = tick ? '0 : presc_q + PRE_W'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
  end

  // Blink half-period counter; blink_sync restarts the "on" half immediately.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLK_W'(1);
    blink_state_d = blink_state_q;
    if (blink_sync_i) begin
      blink_cnt_d   = '0;
      blink_state_d = 1'b1;
    end else if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d   = '0;
      blink_state_d = ~blink_state_q;
    end
  end

  // Timebase state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_state_q <= 1'b1;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_state_q <= blink_state_d;
    end
  end

`ifdef RGB_LED_BREATHE_EN
  logic [PWM_W-1:0] breathe_lvl_q, breathe_lvl_d;
  breathe_dir_e     breathe_dir_q, breathe_dir_d;

  assign breathe_lvl_o = breathe_lvl_q;

  // Triangle wave, one step per frame; reversing at an endpoint steps away
  // from it immediately so each endpoint lasts exactly one frame.
  always_comb begin
    breathe_lvl_d = breathe_lvl_q;
    breathe_dir_d = breathe_dir_q;
    if (frame_start_o) begin
      if (breathe_dir_q == DIR_UP) begin
        if (breathe_lvl_q == '1) begin
          breathe_dir_d = DIR_DOWN;
          breathe_lvl_d = breathe_lvl_q - PWM_W'(1);
        end else begin
          breathe_lvl_d = breathe_lvl_q + PWM_W'(1);
        end
      end else begin
        if (breathe_lvl_q == '0) begin
          breathe_dir_d = DIR_UP;
          breathe_lvl_d = breathe_lvl_q + PWM_W'(1);
        end else begin
          breathe_lvl_d = breathe_lvl_q - PWM_W'(1);
        end
      end
    end
  end

  // Breathe level and direction registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      breathe_lvl_q <= '0;
      breathe_dir_q <= DIR_UP;
    end else begin
      breathe_lvl_q <= breathe_lvl_d;
      breathe_dir_q <= breathe_dir_d;
    end
  end
`endif

endmodule

// File: rtl/rgb_led_array_ctrl.sv
// Multi-LED RGB controller: per-LED colour/mode/level, one-entry config buffer
// committed at PWM frame boundaries, registered pin outputs.
// Optional feature macro: RGB_LED_BREATHE_EN (without it mode 11 acts as STEADY).
module rgb_led_array_ctrl
  import rgb_led_pkg::*;
#(
  parameter int unsigned NUM_LED    = 4,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned TICK_DIV   = 195,
  parameter int unsigned BLINK_HALF = 25000000,
  parameter bit          ACTIVE_LOW = 1'b1,
  localparam int unsigned IDX_W     = idx_width(NUM_LED)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [2:0]         cfg_color,
  input  logic [1:0]         cfg_mode,
  input  logic [PWM_W-1:0]   cfg_level,
  input  logic               blink_sync,
  output logic [NUM_LED-1:0] r_out,
  output logic [NUM_LED-1:0] g_out,
  output logic [NUM_LED-1:0] b_out
);

  localparam logic [NUM_LED-1:0] PIN_IDLE = {NUM_LED{ACTIVE_LOW}};

  logic [PWM_W-1:0] pwm_cnt;
  logic             frame_start;
  logic             blink_state;

  // Pending write buffer.
  logic             pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [2:0]       pend_color_q, pend_color_d;
  led_mode_e        pend_mode_q, pend_mode_d;
  logic [PWM_W-1:0] pend_level_q, pend_level_d;

  // Per-LED configuration.
  logic [2:0]       color_q [NUM_LED];
  logic [2:0]       color_d [NUM_LED];
  led_mode_e        mode_q  [NUM_LED];
  led_mode_e        mode_d  [NUM_LED];
  logic [PWM_W-1:0] level_q [NUM_LED];
  logic [PWM_W-1:0] level_d [NUM_LED];

  logic [NUM_LED-1:0][PWM_W-1:0] eff;
  logic [NUM_LED-1:0]            lit;
  logic [NUM_LED-1:0]            r_on, g_on, b_on;
  logic [NUM_LED-1:0]            r_out_q, r_out_d;
  logic [NUM_LED-1:0]            g_out_q, g_out_d;
  logic [NUM_LED-1:0]            b_out_q, b_out_d;

`ifdef RGB_LED_BREATHE_EN
  logic [PWM_W-1:0]   breathe_lvl;
  logic [2*PWM_W-1:0] breathe_prod [NUM_LED];
`endif

  rgb_pwm_timebase #(
    .PWM_W      (PWM_W),
    .TICK_DIV   (TICK_DIV),
    .BLINK_HALF (BLINK_HALF)
  ) u_timebase (
    .clk_i         (clk),
    .rst_i         (rst),
    .blink_sync_i  (blink_sync),
    .pwm_cnt_o     (pwm_cnt),
    .frame_start_o (frame_start),
    .blink_state_o (blink_state)
`ifdef RGB_LED_BREATHE_EN
    ,
    .breathe_lvl_o (breathe_lvl)
`endif
  );

  assign cfg_ready = ~pend_valid_q;
  assign r_out     = r_out_q;
  assign g_out     = g_out_q;
  assign b_out     = b_out_q;

  // Config path: accept into the buffer when empty, commit only on frame_start.
  // A buffer filled on a frame_start cycle is empty at that edge's start, so it
  // naturally waits for the following frame_start.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    pend_color_d = pend_color_q;
    pend_mode_d  = pend_mode_q;
    pend_level_d = pend_level_q;
    color_d      = color_q;
    mode_d       = mode_q;
    level_d      = level_q;
    if (pend_valid_q && frame_start) begin
      pend_valid_d = 1'b0;
      // Out-of-range indices match no LED and are dropped here.
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        if (pend_idx_q == IDX_W'(i)) begin
          color_d[i] = pend_color_q;
          mode_d[i]  = pend_mode_q;
          level_d[i] = pend_level_q;
        end
      end
    end else if (cfg_valid && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_idx_d   = cfg_idx;
      pend_color_d = cfg_color;
      pend_mode_d  = led_mode_e'(cfg_mode);
      pend_level_d = cfg_level;
    end
  end

  // Config state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_color_q <= '0;
      pend_mode_q  <= MODE_OFF;
      pend_level_q <= '0;
      color_q      <= '{default: '0};
      mode_q       <= '{default: MODE_OFF};
      level_q      <= '{default: '0};
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_color_q <= pend_color_d;
      pend_mode_q  <= pend_mode_d;
      pend_level_q <= pend_level_d;
      color_q      <= color_d;
      mode_q       <= mode_d;
      level_q      <= level_d;
    end
  end

`ifdef RGB_LED_BREATHE_EN
  // Full-width product of LED level and the global breathe level.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      breathe_prod[i] = (2*PWM_W)'(level_q[i]) * (2*PWM_W)'(breathe_lvl);
    end
  end
`endif

  // Effective level per LED and PWM compare; full-scale level means always on.
  always_comb begin
    eff  = '0;
    lit  = '0;
    r_on = '0;
    g_on = '0;
    b_on = '0;
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      case (mode_q[i])
        MODE_OFF:     eff[i] = '0;
        MODE_BLINK:   eff[i] = blink_state ? level_q[i] : '0;
`ifdef RGB_LED_BREATHE_EN
        MODE_BREATHE: eff[i] = breathe_prod[i][2*PWM_W-1:PWM_W];
`endif
        default:      eff[i] = level_q[i];
      endcase
      lit[i]  = (pwm_cnt < eff[i]) || (eff[i] == '1);
      r_on[i] = color_q[i][R_BIT] & lit[i];
      g_on[i] = color_q[i][G_BIT] & lit[i];
      b_on[i] = color_q[i][B_BIT] & lit[i];
    end
  end

  // Pin polarity.
  always_comb begin
    r_out_d = ACTIVE_LOW ? ~r_on : r_on;
    g_out_d = ACTIVE_LOW ? ~g_on : g_on;
    b_out_d = ACTIVE_LOW ? ~b_on : b_on;
  end

  // Registered pins, held inactive through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q <= PIN_IDLE;
      g_out_q <= PIN_IDLE;
      b_out_q <= PIN_IDLE;
    end else begin
      r_out_q <= r_out_d;
      g_out_q <= g_out_d;
      b_out_q <= b_out_d;
    end
  end

endmodule
